// File: rtl/ctrl_table_loader.sv
// Control-plane table loader: scatters a valid/ready phit stream into the state table,
// NUM_STAGE ping-pong banked config tables and the inbound buffer, then opens the
// stream_in gate for a counted burst and swaps the active config bank.
module ctrl_table_loader #(
    parameter int unsigned PHIT_W    = 512,
    parameter int unsigned CFG_W     = 48,
    parameter int unsigned IMM_W     = 64,
    parameter int unsigned NUM_STAGE = 6,
    parameter int unsigned ADDR_W    = 5,
    localparam int unsigned STAGE_W  = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_loader,
    input  logic [ADDR_W:0]    num_entry_state,
    input  logic [ADDR_W:0]    num_entry_cfg,
    input  logic [ADDR_W:0]    num_entry_inb,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [PHIT_W-1:0]  wr_data,
    input  logic               stream_valid,
    output logic               ready_stream_in,
    output logic               tbl_wr_en,
    output logic [1:0]         tbl_sel,
    output logic [STAGE_W-1:0] tbl_stage,
    output logic               tbl_bank,
    output logic [ADDR_W-1:0]  tbl_wr_add,
    output logic [CFG_W-1:0]   tbl_wr_ctrl,
    output logic [IMM_W-1:0]   tbl_wr_imm,
    output logic               active_bank,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGE - 1);
    localparam logic [STAGE_W-1:0] STAGE_ONE = STAGE_W'(1);

    localparam logic [1:0] SEL_STATE = 2'd0;
    localparam logic [1:0] SEL_CFG   = 2'd1;
    localparam logic [1:0] SEL_INB   = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StLdState,
        StLdCfg,
        StLdInb,
        StStream,
        StFin
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]      idx_q, idx_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [CW-1:0]      cnt_state_q, cnt_cfg_q, cnt_inb_q;
    logic [CW-1:0]      clamp_state, clamp_cfg, clamp_inb;
    logic [CW-1:0]      cur_cnt;
    logic [CW-1:0]      idx_inc;
    logic               last_entry;
    logic               accept;
    logic               stream_beat;
    logic [1:0]         sel_cur;

    // Only the ctrl and immediate slices of a phit are meaningful.
    generate
        if (PHIT_W - CFG_W > IMM_W) begin : g_mid_bits
            logic unused_wr_mid;
            assign unused_wr_mid = ^wr_data[PHIT_W-CFG_W-1:IMM_W];
        end
    endgenerate

    function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] n);
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    // First non-empty phase following the state-table phase.
    function automatic state_e after_state(input logic [CW-1:0] n_cfg,
                                           input logic [CW-1:0] n_inb);
        if (n_cfg != '0) begin
            return StLdCfg;
        end
        if (n_inb != '0) begin
            return StLdInb;
        end
        return StFin;
    endfunction

    function automatic state_e after_cfg(input logic [CW-1:0] n_inb);
        return (n_inb != '0) ? StLdInb : StFin;
    endfunction

    assign clamp_state = clamp_cnt(num_entry_state);
    assign clamp_cfg   = clamp_cnt(num_entry_cfg);
    assign clamp_inb   = clamp_cnt(num_entry_inb);

    assign wr_ready    = (state_q == StLdState) || (state_q == StLdCfg) || (state_q == StLdInb);
    assign accept      = wr_valid && wr_ready;
    assign stream_beat = stream_valid && ready_stream_in && (state_q == StStream);
    assign busy        = (state_q != StIdle);
    assign idx_inc     = idx_q + ONE;
    assign last_entry  = (idx_inc == cur_cnt);

    // Entry count and table selector of the phase currently being walked.
    always_comb begin
        cur_cnt = '0;
        sel_cur = SEL_STATE;
        unique case (state_q)
            StLdState: cur_cnt = cnt_state_q;
            StLdCfg: begin
                cur_cnt = cnt_cfg_q;
                sel_cur = SEL_CFG;
            end
            StLdInb: begin
                cur_cnt = cnt_inb_q;
                sel_cur = SEL_INB;
            end
            StStream: cur_cnt = cnt_inb_q;
            default: begin
                cur_cnt = '0;
                sel_cur = SEL_STATE;
            end
        endcase
    end

    // Next-state, entry index and stage walk.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        unique case (state_q)
            StIdle: begin
                if (start_loader) begin
                    idx_d   = '0;
                    stage_d = '0;
                    state_d = (clamp_state != '0) ? StLdState : after_state(clamp_cfg, clamp_inb);
                end
            end
            StLdState: begin
                if (accept) begin
                    if (last_entry) begin
                        idx_d   = '0;
                        state_d = after_state(cnt_cfg_q, cnt_inb_q);
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            StLdCfg: begin
                if (accept) begin
                    if (last_entry) begin
                        idx_d = '0;
                        if (stage_q == LAST_STAGE) begin
                            stage_d = '0;
                            state_d = after_cfg(cnt_inb_q);
                        end else begin
                            stage_d = stage_q + STAGE_ONE;
                        end
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            StLdInb: begin
                if (accept) begin
                    if (last_entry) begin
                        idx_d   = '0;
                        state_d = StStream;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            StStream: begin
                if (stream_beat) begin
                    if (last_entry) begin
                        idx_d   = '0;
                        state_d = StFin;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, walk counters and latched entry counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            stage_q     <= '0;
            cnt_state_q <= '0;
            cnt_cfg_q   <= '0;
            cnt_inb_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            if ((state_q == StIdle) && start_loader) begin
                cnt_state_q <= clamp_state;
                cnt_cfg_q   <= clamp_cfg;
                cnt_inb_q   <= clamp_inb;
            end
        end
    end

    // Registered table write port: an accepted beat shows up one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_wr_en   <= 1'b0;
            tbl_sel     <= '0;
            tbl_stage   <= '0;
            tbl_bank    <= 1'b0;
            tbl_wr_add  <= '0;
            tbl_wr_ctrl <= '0;
            tbl_wr_imm  <= '0;
        end else begin
            tbl_wr_en <= accept;
            if (accept) begin
                tbl_sel     <= sel_cur;
                tbl_stage   <= (state_q == StLdCfg) ? stage_q : '0;
                // Config always lands in the bank the datapath is not reading.
                tbl_bank    <= (state_q == StLdCfg) ? ~active_bank : 1'b0;
                tbl_wr_add  <= idx_q[ADDR_W-1:0];
                tbl_wr_ctrl <= wr_data[PHIT_W-1 -: CFG_W];
                tbl_wr_imm  <= wr_data[IMM_W-1:0];
            end
        end
    end

    // Stream gate, completion pulse and bank swap, all aligned to state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_stream_in <= 1'b0;
            done            <= 1'b0;
            active_bank     <= 1'b0;
        end else begin
            ready_stream_in <= (state_d == StStream);
            done            <= (state_d == StFin);
            if ((state_d == StFin) && (state_q != StFin)) begin
                active_bank <= ~active_bank;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_table_loader.sv
// Directed self-checking bench for ctrl_table_loader.
module tb_ctrl_table_loader;

    localparam int unsigned PHIT_W    = 512;
    localparam int unsigned CFG_W     = 48;
    localparam int unsigned IMM_W     = 64;
    localparam int unsigned NUM_STAGE = 6;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned STAGE_W   = 3;
    localparam int DEPTH = 32;

    logic               clk;
    logic               rst;
    logic               start_loader;
    logic [ADDR_W:0]    num_entry_state;
    logic [ADDR_W:0]    num_entry_cfg;
    logic [ADDR_W:0]    num_entry_inb;
    logic               wr_valid;
    logic               wr_ready;
    logic [PHIT_W-1:0]  wr_data;
    logic               stream_valid;
    logic               ready_stream_in;
    logic               tbl_wr_en;
    logic [1:0]         tbl_sel;
    logic [STAGE_W-1:0] tbl_stage;
    logic               tbl_bank;
    logic [ADDR_W-1:0]  tbl_wr_add;
    logic [CFG_W-1:0]   tbl_wr_ctrl;
    logic [IMM_W-1:0]   tbl_wr_imm;
    logic               active_bank;
    logic               busy;
    logic               done;

    ctrl_table_loader #(
        .PHIT_W   (PHIT_W),
        .CFG_W    (CFG_W),
        .IMM_W    (IMM_W),
        .NUM_STAGE(NUM_STAGE),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_loader   (start_loader),
        .num_entry_state(num_entry_state),
        .num_entry_cfg  (num_entry_cfg),
        .num_entry_inb  (num_entry_inb),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .stream_valid   (stream_valid),
        .ready_stream_in(ready_stream_in),
        .tbl_wr_en      (tbl_wr_en),
        .tbl_sel        (tbl_sel),
        .tbl_stage      (tbl_stage),
        .tbl_bank       (tbl_bank),
        .tbl_wr_add     (tbl_wr_add),
        .tbl_wr_ctrl    (tbl_wr_ctrl),
        .tbl_wr_imm     (tbl_wr_imm),
        .active_bank    (active_bank),
        .busy           (busy),
        .done           (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state: write log, cycle stamps, done/ready observations.
    logic [127:0] wr_log[$];
    int           wr_cyc[$];
    int           mon_cyc = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    bit           rdy_seen = 0;
    int           rdy_writes = 0;
    logic         exp_active = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CFG_W-1:0] beat_ctrl(input int seq);
        return 48'hC0DE_0000_0000 | 48'(seq);
    endfunction

    function automatic logic [IMM_W-1:0] beat_imm(input int seq);
        return 64'hFEED_0000_0000_0000 | 64'(seq);
    endfunction

    function automatic logic [PHIT_W-1:0] mk_beat(input int seq);
        logic [PHIT_W-1:0] b;
        b = {PHIT_W{1'b1}};
        b[PHIT_W-1 -: CFG_W] = beat_ctrl(seq);
        b[IMM_W-1:0] = beat_imm(seq);
        return b;
    endfunction

    function automatic logic [127:0] mk_rec(input int sel, input int stage, input logic bank,
                                            input int add, input int seq);
        return {5'b0, 2'(sel), 3'(stage), bank, 5'(add), beat_ctrl(seq), beat_imm(seq)};
    endfunction

    function automatic int clampc(input int n);
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    // Samples registered outputs 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            if (tbl_wr_en) begin
                wr_log.push_back({5'b0, tbl_sel, tbl_stage, tbl_bank, tbl_wr_add,
                                  tbl_wr_ctrl, tbl_wr_imm});
                wr_cyc.push_back(mon_cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = mon_cyc;
            end
            if (ready_stream_in && !rdy_seen) begin
                rdy_seen = 1;
                rdy_writes = wr_log.size();
            end
        end
    end

    // vmode 0: wr_valid held high throughout; 1: toggling. smode 0: stream_valid held; 1: gaps.
    task automatic run_prog(input string tag, input int ns, input int nc, input int ni,
                            input int vmode, input int smode, input bit poke);
        int cs, cc, ci, total, seq, beats, cyc, extra, k, start_cyc;
        logic bank;
        cs = clampc(ns);
        cc = clampc(nc);
        ci = clampc(ni);
        total = cs + NUM_STAGE * cc + ci;
        seq = 0;
        beats = 0;
        cyc = 0;
        extra = 0;
        bank = ~exp_active;
        @(negedge clk);
        wr_log.delete();
        wr_cyc.delete();
        done_cnt = 0;
        rdy_seen = 0;
        rdy_writes = 0;
        start_cyc = mon_cyc;
        num_entry_state = 6'(ns);
        num_entry_cfg = 6'(nc);
        num_entry_inb = 6'(ni);
        start_loader = 1'b1;
        stream_valid = 1'b1;
        wr_valid = (vmode == 0);
        wr_data = mk_beat(0);
        while (cyc < 1000 && extra < 5) begin
            @(negedge clk);
            cyc++;
            start_loader = poke && ready_stream_in;
            wr_valid = (vmode == 0) ? 1'b1 : (cyc % 2 == 1);
            wr_data = mk_beat(seq);
            if (wr_valid && wr_ready) seq++;
            stream_valid = (smode == 0) ? 1'b1 : (cyc % 3 != 0);
            if (stream_valid && ready_stream_in) beats++;
            if (done_cnt > 0) extra++;
        end
        wr_valid = 1'b0;
        stream_valid = 1'b0;
        start_loader = 1'b0;
        exp_active = ~exp_active;

        check({tag, "_nwr"}, 128'(wr_log.size()), 128'(total));
        k = 0;
        for (int i = 0; i < cs; i++) begin
            if (k < wr_log.size())
                check($sformatf("%s_st%0d", tag, i), wr_log[k], mk_rec(0, 0, 1'b0, i, k));
            k++;
        end
        for (int s = 0; s < NUM_STAGE; s++) begin
            for (int i = 0; i < cc; i++) begin
                if (k < wr_log.size())
                    check($sformatf("%s_cfg%0d_%0d", tag, s, i), wr_log[k],
                          mk_rec(1, s, bank, i, k));
                k++;
            end
        end
        for (int i = 0; i < ci; i++) begin
            if (k < wr_log.size())
                check($sformatf("%s_inb%0d", tag, i), wr_log[k], mk_rec(2, 0, 1'b0, i, k));
            k++;
        end
        check({tag, "_beats"}, 128'(beats), 128'(ci));
        check({tag, "_done"}, 128'(done_cnt), 128'd1);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_active"}, 128'(active_bank), 128'(exp_active));
        if (ci > 0) begin
            check({tag, "_rdy_after_wr"}, 128'(rdy_writes), 128'(total));
        end else begin
            check({tag, "_no_stream"}, 128'(rdy_seen), 128'd0);
            if (total > 0 && wr_cyc.size() > 0)
                check({tag, "_done_lat"}, 128'(done_cyc), 128'(wr_cyc[wr_cyc.size()-1]));
            else
                check({tag, "_done_lat"}, 128'(done_cyc), 128'(start_cyc + 1));
        end
        if (vmode == 0 && total > 0 && wr_cyc.size() > 0) begin
            check({tag, "_first_wr"}, 128'(wr_cyc[0]), 128'(start_cyc + 2));
            check({tag, "_contig"}, 128'(wr_cyc[wr_cyc.size()-1] - wr_cyc[0]), 128'(total - 1));
        end
    endtask

    // Asynchronous reset in the middle of a config-table load.
    task automatic reset_mid_cfg();
        @(negedge clk);
        num_entry_state = 6'd2;
        num_entry_cfg = 6'd2;
        num_entry_inb = 6'd16;
        start_loader = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_loader = 1'b0;
            wr_data = mk_beat(i);
        end
        @(negedge clk);
        check("t1_pre_busy", 128'(busy), 128'd1);
        check("t1_pre_sel", 128'({tbl_wr_en, tbl_sel}), 128'(3'b101));
        #1;
        rst = 1'b1;
        #1;
        check("t1_busy", 128'(busy), 128'd0);
        check("t1_wr_ready", 128'(wr_ready), 128'd0);
        check("t1_wr_en", 128'(tbl_wr_en), 128'd0);
        check("t1_active", 128'(active_bank), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        wr_valid = 1'b0;
        exp_active = 1'b0;
        @(negedge clk);
        check("t1_post_busy", 128'(busy), 128'd0);
    endtask

    initial begin
        rst = 1'b1;
        start_loader = 1'b0;
        num_entry_state = '0;
        num_entry_cfg = '0;
        num_entry_inb = '0;
        wr_valid = 1'b0;
        wr_data = '0;
        stream_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_outs", 128'({wr_ready, ready_stream_in, tbl_wr_en, done, active_bank}), 128'd0);
        check("rst_fields", 128'({tbl_sel, tbl_stage, tbl_bank, tbl_wr_add}), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // FIR load, held valid, stream with gaps; cfg into bank 1.
        run_prog("t2", 2, 2, 16, 0, 1, 1'b0);
        // Second load: cfg into bank 0, start pulses during STREAM ignored.
        run_prog("t6", 2, 2, 16, 0, 0, 1'b1);
        // Backpressure on the phit link.
        run_prog("t3", 2, 2, 16, 1, 1, 1'b0);
        // Reset mid LD_CFG while active_bank is 1.
        reset_mid_cfg();
        // Skip and boundary programs.
        run_prog("t5_nocfg", 3, 0, 4, 0, 0, 1'b0);
        run_prog("t5_noinb", 1, 1, 0, 0, 0, 1'b0);
        run_prog("t5_zero", 0, 0, 0, 0, 0, 1'b0);
        run_prog("t5_cfg32", 0, 32, 0, 0, 0, 1'b0);
        run_prog("t5_clamp", 63, 0, 40, 1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
